// File: rtl/tlp_rx.sv
// TLP receive endpoint: decodes 4DW MWr/MRd headers into commands and forwards write payload beats.
// Latency: 1 cycle from an accepted beat to cmd_valid/out_valid; error pulses are 1 cycle, 1 cycle after the beat.
// Backpressure: in_ready drops while a command is pending (IDLE) or the payload register is full and not draining.
//
// Ports:
//   clk, rst_n                                     clock, async active-low reset
//   in_data/in_hdr/in_sop/in_eop/in_valid/in_ready TLP beat input (header sampled on SOP beat)
//   cmd_valid/cmd_ready/cmd_wr/cmd_addr/cmd_len    decoded command channel
//   out_data/out_valid/out_ready/out_last          write payload channel
//   err_unsup/err_len/err_framing                  one-cycle error pulses
module tlp_rx #(
    parameter int DOUBLE_WORD    = 32,
    parameter int HEADER_SIZE    = 4 * DOUBLE_WORD,
    parameter int TLP_DATA_WIDTH = 8 * DOUBLE_WORD
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [TLP_DATA_WIDTH-1:0] in_data,
    input  logic [HEADER_SIZE-1:0]    in_hdr,
    input  logic                      in_sop,
    input  logic                      in_eop,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic                      cmd_valid,
    input  logic                      cmd_ready,
    output logic                      cmd_wr,
    output logic [63:0]               cmd_addr,
    output logic [10:0]               cmd_len,
    output logic [TLP_DATA_WIDTH-1:0] out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_last,
    output logic                      err_unsup,
    output logic                      err_len,
    output logic                      err_framing
);

    localparam int DPB       = TLP_DATA_WIDTH / DOUBLE_WORD;
    localparam int DPB_SHIFT = $clog2(DPB);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        DROP
    } state_t;

    state_t      state, state_nxt;
    logic [7:0]  remaining, rem_nxt;
    // Held low for the first cycle after reset so in_ready reads 0 while in reset.
    logic        run;

    logic [2:0]  fmt;
    logic [4:0]  typ;
    logic [9:0]  len_raw;
    logic [10:0] len_dw;
    logic [11:0] len_round;
    logic [7:0]  nb;
    logic        is_mwr;
    logic        is_mrd;
    logic        accept;

    logic        load_cmd;
    logic        load_out;
    logic        last_nxt;
    logic        unsup_nxt;
    logic        len_nxt;
    logic        framing_nxt;

    // Header bits this block does not interpret (reserved/attr bits, DW1, DW3[1:0]).
    logic        unused_hdr;
    assign unused_hdr = ^{in_hdr[119:106], in_hdr[95:64], in_hdr[1:0]};

    assign fmt       = in_hdr[127:125];
    assign typ       = in_hdr[124:120];
    assign len_raw   = in_hdr[105:96];
    assign len_dw    = (len_raw == 10'd0) ? 11'd1024 : {1'b0, len_raw};
    assign len_round = {1'b0, len_dw} + 12'(DPB - 1);
    assign nb        = 8'(len_round >> DPB_SHIFT);
    assign is_mwr    = (fmt == 3'b011) && (typ == 5'd0);
    assign is_mrd    = (fmt == 3'b001) && (typ == 5'd0);
    assign accept    = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            remaining <= 8'd0;
            run       <= 1'b0;
        end else begin
            state     <= state_nxt;
            remaining <= rem_nxt;
            run       <= 1'b1;
        end
    end

    always_comb begin
        state_nxt   = state;
        rem_nxt     = remaining;
        in_ready    = 1'b0;
        load_cmd    = 1'b0;
        load_out    = 1'b0;
        last_nxt    = 1'b0;
        unsup_nxt   = 1'b0;
        len_nxt     = 1'b0;
        framing_nxt = 1'b0;
        case (state)
            IDLE: begin
                // A new header needs both the command slot and the payload register free.
                in_ready = run && !cmd_valid && (!out_valid || out_ready);
                if (accept) begin
                    if (!in_sop) begin
                        framing_nxt = 1'b1;
                    end else if (!is_mwr && !is_mrd) begin
                        unsup_nxt = 1'b1;
                        if (!in_eop) state_nxt = DROP;
                    end else begin
                        load_cmd = 1'b1;
                        if (is_mrd) begin
                            if (!in_eop) begin
                                len_nxt   = 1'b1;
                                state_nxt = DROP;
                            end
                        end else begin
                            load_out = 1'b1;
                            // An early EOP still closes the payload stream cleanly.
                            last_nxt = (nb == 8'd1) || in_eop;
                            if (nb == 8'd1) begin
                                if (!in_eop) begin
                                    len_nxt   = 1'b1;
                                    state_nxt = DROP;
                                end
                            end else if (in_eop) begin
                                len_nxt = 1'b1;
                            end else begin
                                rem_nxt   = nb - 8'd1;
                                state_nxt = DATA;
                            end
                        end
                    end
                end
            end
            DATA: begin
                in_ready = !out_valid || out_ready;
                if (accept) begin
                    load_out    = 1'b1;
                    framing_nxt = in_sop;
                    rem_nxt     = remaining - 8'd1;
                    last_nxt    = (remaining == 8'd1) || in_eop;
                    if (remaining == 8'd1) begin
                        len_nxt   = !in_eop;
                        state_nxt = in_eop ? IDLE : DROP;
                    end else if (in_eop) begin
                        len_nxt   = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            DROP: begin
                in_ready = 1'b1;
                if (accept && in_eop) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Command register: loaded only when empty, so no load/consume conflict.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_valid <= 1'b0;
            cmd_wr    <= 1'b0;
            cmd_addr  <= 64'd0;
            cmd_len   <= 11'd0;
        end else if (load_cmd) begin
            cmd_valid <= 1'b1;
            cmd_wr    <= is_mwr;
            cmd_addr  <= {in_hdr[63:32], in_hdr[31:2], 2'b00};
            cmd_len   <= len_dw;
        end else if (cmd_ready) begin
            cmd_valid <= 1'b0;
        end
    end

    // Payload register: reloads in the same cycle it drains for full throughput.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (load_out) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
            out_last  <= last_nxt;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_unsup   <= 1'b0;
            err_len     <= 1'b0;
            err_framing <= 1'b0;
        end else begin
            err_unsup   <= unsup_nxt;
            err_len     <= len_nxt;
            err_framing <= framing_nxt;
        end
    end

endmodule
